// File: rtl/msrv32_lsu_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : msrv32_lsu_store_buffer
//  Purpose  : Load/store unit with an in-order posted-write buffer in front of
//             an AHB-Lite data port. One bus transfer outstanding at a time.
//             Loads bypass buffered stores unless they hit the same word.
//  Options  : MSRV32_SB_FWD_EN - answer fully covered hazard loads from the
//             youngest matching buffer entry instead of waiting for drain.
//  Revision : 1.0 - initial release
// ============================================================================
module msrv32_lsu_store_buffer #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         req_valid_in,
    output logic                         req_ready_out,
    input  logic                         req_we_in,
    input  logic [ADDR_W-1:0]            req_addr_in,
    input  logic [1:0]                   req_size_in,
    input  logic [XLEN-1:0]              req_wdata_in,
    input  logic [XLEN/8-1:0]            req_mask_in,
    output logic                         rsp_valid_out,
    output logic [XLEN-1:0]              rsp_rdata_out,
    output logic                         rsp_err_out,
    output logic                         store_err_out,
    output logic [$clog2(SB_DEPTH):0]    sb_count_out,
    output logic                         sb_empty_out,
    output logic [ADDR_W-1:0]            haddr_out,
    output logic [1:0]                   htrans_out,
    output logic                         hwrite_out,
    output logic [2:0]                   hsize_out,
    output logic [XLEN-1:0]              hwdata_out,
    output logic [XLEN/8-1:0]            wr_mask_out,
    input  logic [XLEN-1:0]              hrdata_in,
    input  logic                         hready_in,
    input  logic                         hresp_in
);
    localparam int NB    = XLEN / 8;
    localparam int OFF   = $clog2(NB);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Buffer storage; the head entry stays resident while its write is on the bus
    logic [ADDR_W-1:0] sb_addr  [SB_DEPTH];
    logic [XLEN-1:0]   sb_wdata [SB_DEPTH];
    logic [NB-1:0]     sb_mask  [SB_DEPTH];
    logic [1:0]        sb_size  [SB_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              load_pending;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_size;
    logic              cur_write;

    logic              push, pop, ld_accept, ld_done, xfer_done, load_on_bus;
    logic              eff_ld_valid;
    logic [ADDR_W-1:0] eff_ld_addr;
    logic [1:0]        eff_ld_size;
    logic              hazard, issue_load, issue_store, fwd_hit;

    assign req_ready_out = !load_pending && (req_we_in ? (count < CNT_W'(SB_DEPTH)) : 1'b1);
    assign push          = req_valid_in && req_ready_out && req_we_in;
    assign ld_accept     = req_valid_in && req_ready_out && !req_we_in;
    assign xfer_done     = (state == ST_DATA) && hready_in;
    assign pop           = xfer_done && cur_write;
    assign ld_done       = xfer_done && !cur_write;
    assign load_on_bus   = (state != ST_IDLE) && !cur_write;

    // A load arriving this cycle may go straight to the bus from IDLE
    assign eff_ld_valid  = load_pending || ld_accept;
    assign eff_ld_addr   = load_pending ? ld_addr : req_addr_in;
    assign eff_ld_size   = load_pending ? ld_size : req_size_in;

    assign htrans_out    = (state == ST_ADDR) ? 2'b10 : 2'b00;
    assign sb_count_out  = count;
    assign sb_empty_out  = (count == '0) && !((state != ST_IDLE) && cur_write);

`ifdef MSRV32_SB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    function automatic logic [NB-1:0] load_lanes(input logic [OFF-1:0] off, input logic [1:0] sz);
        int n;
        n = 1 << sz;
        return NB'((1 << n) - 1) << off;
    endfunction
`endif

    // Same-word scan over valid entries, oldest to youngest (youngest wins)
    always_comb begin
        logic [PTR_W-1:0] idx;
        hazard = 1'b0;
        idx    = '0;
`ifdef MSRV32_SB_FWD_EN
        fwd_idx = rd_ptr;
`endif
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (sb_addr[idx][ADDR_W-1:OFF] == eff_ld_addr[ADDR_W-1:OFF])) begin
                hazard = 1'b1;
`ifdef MSRV32_SB_FWD_EN
                fwd_idx = idx;
`endif
            end
        end
    end

`ifdef MSRV32_SB_FWD_EN
    assign fwd_hit = load_pending && !load_on_bus && hazard &&
                     ((load_lanes(ld_addr[OFF-1:0], ld_size) & ~sb_mask[fwd_idx]) == '0);
`else
    assign fwd_hit = 1'b0;
`endif

    // Bus FSM state register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state: hazard-free loads first, otherwise drain the head store
    always_comb begin
        state_nxt   = state;
        issue_load  = 1'b0;
        issue_store = 1'b0;
        case (state)
            ST_IDLE: begin
                if (eff_ld_valid && !hazard) begin
                    issue_load = 1'b1;
                    state_nxt  = ST_ADDR;
                end else if (count != '0) begin
                    issue_store = 1'b1;
                    state_nxt   = ST_ADDR;
                end
            end
            ST_ADDR: if (hready_in) state_nxt = ST_DATA;
            ST_DATA: if (hready_in) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Buffer payload write; contents are meaningless outside the valid window
    always_ff @(posedge clk_in) begin
        if (push) begin
            sb_addr[wr_ptr]  <= req_addr_in;
            sb_wdata[wr_ptr] <= req_wdata_in;
            sb_mask[wr_ptr]  <= req_mask_in;
            sb_size[wr_ptr]  <= req_size_in;
        end
    end

    // Pointers, occupancy, load tracking, bus address/data and responses
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            load_pending  <= 1'b0;
            ld_addr       <= '0;
            ld_size       <= '0;
            cur_write     <= 1'b0;
            store_err_out <= 1'b0;
            rsp_valid_out <= 1'b0;
            rsp_rdata_out <= '0;
            rsp_err_out   <= 1'b0;
            haddr_out     <= '0;
            hwrite_out    <= 1'b0;
            hsize_out     <= '0;
            hwdata_out    <= '0;
            wr_mask_out   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop && hresp_in) store_err_out <= 1'b1;

            if (ld_accept) begin
                load_pending <= 1'b1;
                ld_addr      <= req_addr_in;
                ld_size      <= req_size_in;
            end else if (ld_done || fwd_hit) begin
                load_pending <= 1'b0;
            end

            rsp_valid_out <= ld_done || fwd_hit;
            rsp_err_out   <= ld_done && hresp_in;
            if (ld_done) begin
                rsp_rdata_out <= hresp_in ? '0 : hrdata_in;
            end
`ifdef MSRV32_SB_FWD_EN
            else if (fwd_hit) begin
                rsp_rdata_out <= sb_wdata[fwd_idx];
            end
`endif

            if (issue_load) begin
                cur_write  <= 1'b0;
                haddr_out  <= eff_ld_addr;
                hwrite_out <= 1'b0;
                hsize_out  <= {1'b0, eff_ld_size};
            end else if (issue_store) begin
                cur_write  <= 1'b1;
                haddr_out  <= sb_addr[rd_ptr];
                hwrite_out <= 1'b1;
                hsize_out  <= {1'b0, sb_size[rd_ptr]};
            end

            if ((state == ST_ADDR) && hready_in) begin
                hwdata_out  <= cur_write ? sb_wdata[rd_ptr] : '0;
                wr_mask_out <= cur_write ? sb_mask[rd_ptr]  : '0;
            end else if (xfer_done) begin
                hwdata_out  <= '0;
                wr_mask_out <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msrv32_lsu_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msrv32_lsu_store_buffer
//  Purpose  : Self-checking bench: single-transaction vector table plus
//             directed sequences for buffer full, hazards, wait states, reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_msrv32_lsu_store_buffer;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic        req_we_in = 1'b0;
    logic [31:0] req_addr_in = '0;
    logic [1:0]  req_size_in = '0;
    logic [31:0] req_wdata_in = '0;
    logic [3:0]  req_mask_in = '0;
    logic        rsp_valid_out;
    logic [31:0] rsp_rdata_out;
    logic        rsp_err_out;
    logic        store_err_out;
    logic [2:0]  sb_count_out;
    logic        sb_empty_out;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [31:0] hwdata_out;
    logic [3:0]  wr_mask_out;
    logic [31:0] hrdata_in = '0;
    logic        hready_in = 1'b1;
    logic        hresp_in = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    msrv32_lsu_store_buffer #(.XLEN(32), .ADDR_W(32), .SB_DEPTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_we_in(req_we_in), .req_addr_in(req_addr_in), .req_size_in(req_size_in),
        .req_wdata_in(req_wdata_in), .req_mask_in(req_mask_in),
        .rsp_valid_out(rsp_valid_out), .rsp_rdata_out(rsp_rdata_out), .rsp_err_out(rsp_err_out),
        .store_err_out(store_err_out), .sb_count_out(sb_count_out), .sb_empty_out(sb_empty_out),
        .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out),
        .hsize_out(hsize_out), .hwdata_out(hwdata_out), .wr_mask_out(wr_mask_out),
        .hrdata_in(hrdata_in), .hready_in(hready_in), .hresp_in(hresp_in)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] hrdata;
        logic        hresp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_store_err;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req_valid_in = 1'b0;
        hready_in    = 1'b1;
        hresp_in     = 1'b0;
        rst_in       = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
        tick();
    endtask

    task automatic drive_req(input logic we, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd, input logic [3:0] m);
        req_valid_in = 1'b1;
        req_we_in    = we;
        req_addr_in  = a;
        req_size_in  = sz;
        req_wdata_in = wd;
        req_mask_in  = m;
    endtask

    // One request from an idle, empty unit with a zero-wait bus
    task automatic run_vec(input int k, input vec_t v);
        int          addr_cyc = -1;
        int          rsp_cyc  = -1;
        logic [31:0] a_addr = '0, a_wd = '0, r_data = '0;
        logic        a_wr = 1'b0, r_err = 1'b0;
        logic [2:0]  a_sz = '0;
        logic [3:0]  a_m = '0;
        hrdata_in = v.hrdata;
        hresp_in  = v.hresp;
        hready_in = 1'b1;
        drive_req(v.we, v.addr, v.size, v.wdata, v.mask);
        check($sformatf("vec%0d ready", k), req_ready_out, 1);
        tick();
        req_valid_in = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (htrans_out == 2'b10 && addr_cyc < 0) begin
                addr_cyc = c; a_addr = haddr_out; a_wr = hwrite_out; a_sz = hsize_out;
            end
            if (addr_cyc > 0 && c == addr_cyc + 1) begin
                a_wd = hwdata_out; a_m = wr_mask_out;
            end
            if (rsp_valid_out) begin
                rsp_cyc = c; r_data = rsp_rdata_out; r_err = rsp_err_out;
            end
            tick();
        end
        check($sformatf("vec%0d addr_cycle", k), 64'(addr_cyc), v.we ? 64'd2 : 64'd1);
        check($sformatf("vec%0d haddr", k), a_addr, v.addr);
        check($sformatf("vec%0d hwrite", k), a_wr, v.we);
        check($sformatf("vec%0d hsize", k), a_sz, {1'b0, v.size});
        if (v.we) begin
            check($sformatf("vec%0d hwdata", k), a_wd, v.wdata);
            check($sformatf("vec%0d wr_mask", k), a_m, v.mask);
            check($sformatf("vec%0d no_rsp", k), 64'(rsp_cyc), 64'(-1));
        end else begin
            check($sformatf("vec%0d rsp_cycle", k), 64'(rsp_cyc), 64'd3);
            check($sformatf("vec%0d rdata", k), r_data, v.exp_rdata);
            check($sformatf("vec%0d rsp_err", k), r_err, v.exp_err);
        end
        check($sformatf("vec%0d store_err", k), store_err_out, v.exp_store_err);
        check($sformatf("vec%0d empty", k), sb_empty_out, 1);
        hresp_in = 1'b0;
    endtask

    initial begin
        int          n;
        int          rsp_cyc;
        logic [31:0] r_data;
        logic [31:0] order [4];
        logic        tw [4];
        logic [31:0] ta [4];
        logic        ok;

        //            we   addr          sz    wdata         mask     hrdata        hresp rdata         err  serr
        vecs[0] = '{1'b0, 32'h0000_0100, 2'd2, 32'h0,        4'h0,    32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0200, 2'd2, 32'h1122_3344, 4'hF,   32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0301, 2'd0, 32'h0000_AB00, 4'b0010, 32'h0,        1'b0, 32'h0,         1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0302, 2'd1, 32'h0,        4'h0,    32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0040, 2'd2, 32'h55AA_55AA, 4'hF,   32'h0,         1'b1, 32'h0,         1'b0, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0080, 2'd2, 32'h0,        4'h0,    32'h1234_5678, 1'b1, 32'h0,         1'b1, 1'b1};

        // Reset state
        rst_in = 1'b0;
        tick();
        check("rst htrans", htrans_out, 2'b00);
        check("rst count", sb_count_out, 0);
        check("rst empty", sb_empty_out, 1);
        check("rst rsp_valid", rsp_valid_out, 0);
        check("rst store_err", store_err_out, 0);
        check("rst haddr", haddr_out, 0);
        check("rst hwdata", hwdata_out, 0);
        rst_in = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

        // Reset asserted in the middle of a stalled store
        hready_in = 1'b0;
        drive_req(1'b1, 32'h0000_0044, 2'd2, 32'h0BAD_F00D, 4'hF);
        tick();
        req_valid_in = 1'b0;
        tick();
        check("midrst in_addr", htrans_out, 2'b10);
        #2 rst_in = 1'b0;
        #1;
        req_we_in = 1'b1;
        #1;
        check("midrst htrans", htrans_out, 2'b00);
        check("midrst count", sb_count_out, 0);
        check("midrst empty", sb_empty_out, 1);
        check("midrst ready", req_ready_out, 1);
        check("midrst store_err", store_err_out, 0);
        tick();
        rst_in = 1'b1;
        hready_in = 1'b1;
        tick();

        // Fill the buffer while the bus stalls, then drain in order
        hready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 32'h10 + 32'(4 * i), 2'd2, 32'hA0 + 32'(i), 4'hF);
            check($sformatf("full ready%0d", i), req_ready_out, 1);
            tick();
        end
        drive_req(1'b1, 32'h20, 2'd2, 32'hA4, 4'hF);
        check("full 5th ready", req_ready_out, 0);
        check("full count", sb_count_out, 4);
        req_valid_in = 1'b0;
        tick();
        check("full head held", haddr_out, 32'h10);
        hready_in = 1'b1;
        n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            if (htrans_out == 2'b10) begin
                order[n] = haddr_out;
                n++;
            end
            tick();
        end
        check("drain transfers", 64'(n), 4);
        for (int i = 0; i < 4; i++) check($sformatf("drain order%0d", i), order[i], 32'h10 + 32'(4 * i));
        tick();
        tick();
        check("drain count", sb_count_out, 0);
        check("drain empty", sb_empty_out, 1);

        // Load to a different word overtakes a buffered store
        hrdata_in = 32'h9988_7766;
        drive_req(1'b1, 32'h200, 2'd2, 32'h1122_3344, 4'hF);
        tick();
        drive_req(1'b0, 32'h204, 2'd2, 32'h0, 4'h0);
        tick();
        req_valid_in = 1'b0;
        n = 0; rsp_cyc = -1; r_data = '0;
        for (int c = 1; c <= 12; c++) begin
            if (htrans_out == 2'b10 && n < 4) begin
                tw[n] = hwrite_out; ta[n] = haddr_out; n++;
            end
            if (rsp_valid_out) begin rsp_cyc = c; r_data = rsp_rdata_out; end
            tick();
        end
        check("ovt transfers", 64'(n), 2);
        check("ovt first hwrite", tw[0], 0);
        check("ovt first haddr", ta[0], 32'h204);
        check("ovt second hwrite", tw[1], 1);
        check("ovt second haddr", ta[1], 32'h200);
        check("ovt rsp_cycle", 64'(rsp_cyc), 3);

        // Load to the same word as a buffered store
        drive_req(1'b1, 32'h200, 2'd2, 32'h1122_3344, 4'hF);
        tick();
        drive_req(1'b0, 32'h200, 2'd2, 32'h0, 4'h0);
        tick();
        req_valid_in = 1'b0;
        n = 0; rsp_cyc = -1; r_data = '0;
        for (int c = 1; c <= 12; c++) begin
            if (htrans_out == 2'b10 && n < 4) begin
                tw[n] = hwrite_out; ta[n] = haddr_out; n++;
            end
            if (rsp_valid_out) begin rsp_cyc = c; r_data = rsp_rdata_out; end
            tick();
        end
        check("haz first hwrite", tw[0], 1);
        check("haz first haddr", ta[0], 32'h200);
`ifdef MSRV32_SB_FWD_EN
        check("haz transfers", 64'(n), 1);
        check("haz rsp_cycle", 64'(rsp_cyc), 2);
        check("haz rdata", r_data, 32'h1122_3344);
`else
        check("haz transfers", 64'(n), 2);
        check("haz second hwrite", tw[1], 0);
        check("haz second haddr", ta[1], 32'h200);
        check("haz rsp_cycle", 64'(rsp_cyc), 6);
        check("haz rdata", r_data, 32'h9988_7766);
`endif

        // Load with 3 wait states in address and data phase
        hrdata_in = 32'h0F1E_2D3C;
        hready_in = 1'b0;
        drive_req(1'b0, 32'h100, 2'd2, 32'h0, 4'h0);
        tick();
        req_valid_in = 1'b0;
        ok = 1'b1; rsp_cyc = -1; r_data = '0;
        for (int c = 1; c <= 11; c++) begin
            hready_in = (c == 4 || c == 8);
            if (c <= 4 && (htrans_out != 2'b10 || haddr_out != 32'h100)) ok = 1'b0;
            if (c >= 5 && c <= 8 && htrans_out != 2'b00) ok = 1'b0;
            if (rsp_valid_out) begin rsp_cyc = c; r_data = rsp_rdata_out; end
            tick();
        end
        check("wait ld stable", ok, 1);
        check("wait ld rsp_cycle", 64'(rsp_cyc), 9);
        check("wait ld rdata", r_data, 32'h0F1E_2D3C);

        // Store with 3 wait states in address and data phase
        hready_in = 1'b0;
        drive_req(1'b1, 32'h300, 2'd2, 32'h5A5A_A5A5, 4'b1100);
        tick();
        req_valid_in = 1'b0;
        ok = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            hready_in = (c == 5 || c == 9);
            if (c >= 2 && c <= 5 && (htrans_out != 2'b10 || haddr_out != 32'h300)) ok = 1'b0;
            if (c >= 6 && c <= 9 && (hwdata_out != 32'h5A5A_A5A5 || wr_mask_out != 4'b1100)) ok = 1'b0;
            tick();
        end
        check("wait st stable", ok, 1);
        check("wait st empty", sb_empty_out, 1);
        check("wait st store_err", store_err_out, 0);

        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
